dither_rgb_stream: RTL and testbench

Parametrised multi-channel ditherer that reduces each colour channel of a pixel stream from IN_W to OUT_W bits. It supports truncation, 1-D error diffusion (the per-channel residual is carried to the next pixel) and 4x4 ordered (Bayer) dithering. It sits between the pixel source and the VGA colour output and uses valid/ready handshakes on both sides. Diffusion error and Bayer position are reset at line and frame boundaries.

---
 rtl/dither_pkg.sv | 21 ++
 rtl/dither_channel.sv | 42 ++++
 rtl/dither_rgb_stream.sv | 81 ++++++++
 tb/tb_dither_rgb_stream.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dither_pkg.sv
// dither_pkg: shared mode encoding, Bayer matrix and saturation helper for the ditherer.
package dither_pkg;

    typedef enum logic [1:0] {
        TRUNC   = 2'd0,
        DIFFUSE = 2'd1,
        BAYER   = 2'd2
    } dither_mode_e;

    localparam logic [3:0] BAYER4 [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6},
        '{4'd3,  4'd11, 4'd1,  4'd9},
        '{4'd15, 4'd7,  4'd13, 4'd5}
    };

    function automatic int sat(input int v, input int lo, input int hi);
        return v < lo ? lo : (v > hi ? hi : v);
    endfunction

endpackage

// File: rtl/dither_channel.sv
// dither_channel: one colour channel's quantizer for all modes plus its diffusion error register.
module dither_channel
    import dither_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_val,
    input  logic [1:0]       mode,
    input  logic [3:0]       m_val,
    input  logic             sol,
    input  logic             accept,
    output logic [OUT_W-1:0] q
);

    localparam int D    = IN_W - OUT_W;
    localparam int EW   = D + 1;
    localparam int QMAX = 2 ** OUT_W - 1;

    logic signed [EW-1:0] err_q, err_d;
    int e, s, qd, qb, qt, en;

    always_comb begin
        e  = sol ? 0 : int'(err_q);
        s  = int'(in_val) + e;
        qd = sat((s + 2 ** (D - 1)) >>> D, 0, QMAX);
        en = sat(s - (qd << D), -(2 ** (D - 1)), 2 ** (D - 1) - 1);
        // bias scales the 4-bit matrix entry onto the D fractional bits
        qb = sat((int'(in_val) + ((int'(m_val) << D) >>> 4)) >>> D, 0, QMAX);
        qt = int'(in_val) >>> D;
        q  = OUT_W'(mode == DIFFUSE ? qd : (mode == BAYER ? qb : qt));
        err_d = !accept ? err_q : (mode == DIFFUSE ? EW'(en) : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= '0;
        else     err_q <= err_d;
    end

endmodule

// File: rtl/dither_rgb_stream.sv
// dither_rgb_stream: valid/ready pixel ditherer with per-channel quantizers and one output register stage.
module dither_rgb_stream
    import dither_pkg::*;
#(
    parameter int CH    = 3,
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH*IN_W-1:0]  in_pix,
    input  logic                in_sol,
    input  logic                in_sof,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH*OUT_W-1:0] out_pix,
    output logic                out_sol,
    output logic                out_sof
);

    logic                accept;
    logic [1:0]          col_q, col_d, col_use, row_q, row_d, row_use;
    logic [3:0]          m_val;
    logic                valid_q, valid_d, sol_q, sol_d, sof_q, sof_d;
    logic [CH*OUT_W-1:0] pix_q, pix_d, q_all;

    assign in_ready = !valid_q || out_ready;

    always_comb begin
        accept  = in_valid && in_ready;
        col_use = in_sol ? 2'd0 : col_q;
        row_use = in_sof ? 2'd0 : (in_sol ? row_q + 2'd1 : row_q);
        m_val   = BAYER4[row_use][col_use];
        col_d   = accept ? col_use + 2'd1 : col_q;
        row_d   = accept ? row_use : row_q;
        valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : valid_q);
        pix_d   = accept ? q_all : pix_q;
        sol_d   = accept ? in_sol : sol_q;
        sof_d   = accept ? in_sof : sof_q;
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        dither_channel #(.IN_W(IN_W), .OUT_W(OUT_W)) u_ch (
            .clk    (clk),
            .rst    (rst),
            .in_val (in_pix[c*IN_W +: IN_W]),
            .mode   (mode),
            .m_val  (m_val),
            .sol    (in_sol),
            .accept (accept),
            .q      (q_all[c*OUT_W +: OUT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pix_q   <= '0;
            sol_q   <= 1'b0;
            sof_q   <= 1'b0;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
        end else begin
            valid_q <= valid_d;
            pix_q   <= pix_d;
            sol_q   <= sol_d;
            sof_q   <= sof_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pix   = pix_q;
    assign out_sol   = sol_q;
    assign out_sof   = sof_q;

endmodule

// File: tb/tb_dither_rgb_stream.sv
// tb_dither_rgb_stream: directed vectors with hand-computed expectations for the 3x8->3x4 ditherer.
module tb_dither_rgb_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_pix = '0;
    logic        in_sol = 1'b0;
    logic        in_sof = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_pix;
    logic        out_sol;
    logic        out_sof;

    int total = 0;
    int bad = 0;

    dither_rgb_stream #(.CH(3), .IN_W(8), .OUT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pix    (in_pix),
        .in_sol    (in_sol),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_sol   (out_sol),
        .out_sof   (out_sof)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [1:0] m, input logic [23:0] px, input logic sol, input logic sof);
        mode = m; in_pix = px; in_sol = sol; in_sof = sof; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sol = 1'b0; in_sof = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pix", 32'(out_pix), 32'h000);
        chk("rst_sol", 32'(out_sol), 32'd0);
        chk("rst_sof", 32'(out_sof), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        beat(2'd1, 24'h888888, 1'b1, 1'b0);
        chk("dif88_0", 32'(out_pix), 32'h999);
        chk("dif88_sol", 32'(out_sol), 32'd1);
        chk("dif88_valid", 32'(out_valid), 32'd1);
        beat(2'd1, 24'h888888, 1'b0, 1'b0);
        chk("dif88_1", 32'(out_pix), 32'h888);
        chk("dif88_sol1", 32'(out_sol), 32'd0);
        beat(2'd1, 24'h888888, 1'b0, 1'b0);
        chk("dif88_2", 32'(out_pix), 32'h999);
        beat(2'd1, 24'h888888, 1'b0, 1'b0);
        chk("dif88_3", 32'(out_pix), 32'h888);

        beat(2'd1, 24'hFFFFFF, 1'b1, 1'b0);
        chk("difff_0", 32'(out_pix), 32'hFFF);
        beat(2'd1, 24'hFFFFFF, 1'b0, 1'b0);
        chk("difff_1", 32'(out_pix), 32'hFFF);
        beat(2'd1, 24'hFFFFFF, 1'b0, 1'b0);
        chk("difff_2", 32'(out_pix), 32'hFFF);
        beat(2'd1, 24'h000000, 1'b0, 1'b0);
        chk("difff_sat7", 32'(out_pix), 32'h000);
        beat(2'd1, 24'h000000, 1'b1, 1'b0);
        chk("difff_sol0", 32'(out_pix), 32'h000);

        beat(2'd0, 24'h8F8F8F, 1'b0, 1'b0);
        chk("trunc_8f", 32'(out_pix), 32'h888);
        beat(2'd3, 24'h8F8F8F, 1'b0, 1'b0);
        chk("rsvd_8f", 32'(out_pix), 32'h888);
        beat(2'd0, 24'h8F3C01, 1'b0, 1'b0);
        chk("trunc_mix", 32'(out_pix), 32'h830);

        beat(2'd1, 24'h888888, 1'b1, 1'b0);
        chk("leave_dif_a", 32'(out_pix), 32'h999);
        beat(2'd0, 24'h888888, 1'b0, 1'b0);
        beat(2'd1, 24'h888888, 1'b0, 1'b0);
        chk("leave_dif_clr", 32'(out_pix), 32'h999);

        beat(2'd2, 24'h888888, 1'b1, 1'b1);
        chk("bay_r0c0", 32'(out_pix), 32'h888);
        chk("bay_sof", 32'(out_sof), 32'd1);
        beat(2'd2, 24'h888888, 1'b0, 1'b0);
        chk("bay_r0c1", 32'(out_pix), 32'h999);
        beat(2'd2, 24'h888888, 1'b0, 1'b0);
        chk("bay_r0c2", 32'(out_pix), 32'h888);
        beat(2'd2, 24'hFFFFFF, 1'b0, 1'b0);
        chk("bay_clamp", 32'(out_pix), 32'hFFF);
        beat(2'd2, 24'h888888, 1'b1, 1'b0);
        chk("bay_r1c0", 32'(out_pix), 32'h999);
        beat(2'd2, 24'h888888, 1'b0, 1'b0);
        chk("bay_r1c1", 32'(out_pix), 32'h888);
        beat(2'd2, 24'h888888, 1'b1, 1'b1);
        chk("bay_sof_r0", 32'(out_pix), 32'h888);

        beat(2'd1, 24'h888888, 1'b1, 1'b0);
        chk("bp_first", 32'(out_pix), 32'h999);
        out_ready = 1'b0;
        mode = 2'd1; in_pix = 24'h888888; in_valid = 1'b1;
        #1;
        chk("bp_ready_lo", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_pix", 32'(out_pix), 32'h999);
            chk("bp_hold_rdy", 32'(in_ready) | (32'(out_valid) << 1), 32'd2);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_hi", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_release", 32'(out_pix), 32'h888);
        beat(2'd1, 24'h888888, 1'b0, 1'b0);
        chk("bp_next", 32'(out_pix), 32'h999);

        beat(2'd1, 24'h888888, 1'b1, 1'b0);
        do_reset;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_pix", 32'(out_pix), 32'h000);
        beat(2'd1, 24'h888888, 1'b0, 1'b0);
        chk("mrst_err0", 32'(out_pix), 32'h999);

        beat(2'd2, 24'h878787, 1'b1, 1'b1);
        beat(2'd2, 24'h878787, 1'b1, 1'b0);
        beat(2'd2, 24'h878787, 1'b0, 1'b0);
        do_reset;
        chk("mrst2_valid", 32'(out_valid), 32'd0);
        beat(2'd2, 24'h878787, 1'b0, 1'b0);
        chk("mrst_c0", 32'(out_pix), 32'h888);
        beat(2'd2, 24'h878787, 1'b0, 1'b0);
        chk("mrst_c1", 32'(out_pix), 32'h888);
        beat(2'd2, 24'h878787, 1'b0, 1'b0);
        chk("mrst_c2", 32'(out_pix), 32'h888);
        beat(2'd2, 24'h878787, 1'b0, 1'b0);
        chk("mrst_c3", 32'(out_pix), 32'h999);

        repeat (2) @(posedge clk);
        #1;
        chk("idle_valid", 32'(out_valid), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
